// File: rtl/assertion_shaper_pkg.sv
// Shared types and defaults for the assertion shaper.
//   shape_mode_t : per-channel shaping mode (off / echo / trip / one-shot)
//   SHP_DEF_*    : default parameter values used by the top level
package assertion_shaper_pkg;

    typedef enum logic [1:0] {
        SHP_OFF     = 2'b00,
        SHP_ECHO    = 2'b01,
        SHP_TRIP    = 2'b10,
        SHP_ONESHOT = 2'b11
    } shape_mode_t;

    localparam int SHP_DEF_CHANNELS = 4;
    localparam int SHP_DEF_LAT_W    = 3;

endpackage

// File: rtl/assertion_shaper_channel.sv
// One independent shaping channel.
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_trigger        : one-cycle event input
//   i_mode           : requested shaping mode (registered into r_mode_q)
//   i_latency        : latency L, 0 .. 2**LAT_W-1
//   i_kill           : drop all pending activity at the next edge
//   i_clr_overrun    : clear the sticky overrun flag
//   o_assertion      : shaped output (combinational from state and inputs)
//   o_busy           : channel holds pending state (pre-edge view)
//   o_overrun        : sticky, a one-shot trigger was dropped while busy
module assertion_shaper_channel
    import assertion_shaper_pkg::*;
#(
    parameter int LAT_W         = 3,
    parameter bit IMMEDIATE_BIT = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_trigger,
    input  shape_mode_t       i_mode,
    input  logic [LAT_W-1:0]  i_latency,
    input  logic              i_kill,
    input  logic              i_clr_overrun,
    output logic              o_assertion,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int LMAX = (1 << LAT_W) - 1;

    shape_mode_t      r_mode_q;
    logic [LAT_W-1:0] r_cnt;      // echo timer or one-shot countdown
    logic [LMAX-1:0]  r_line;     // trip delay line, bit k = trigger k+1 cycles ago
    logic             r_overrun;

    logic [LAT_W-1:0] w_cnt_nxt;
    logic [LMAX-1:0]  w_line_nxt;
    logic [LMAX-1:0]  w_mask;
    logic             w_mode_chg;
    logic             w_trig;
    logic             w_tap;
    logic             w_cnt_nz;
    logic             w_overrun_set;
    logic             w_assert;
    logic             w_busy;

    assign w_mode_chg = (i_mode != r_mode_q);
    // A trigger only takes effect when neither kill nor a mode switch owns the cycle.
    assign w_trig     = i_trigger && !i_kill && !w_mode_chg;
    assign w_cnt_nz   = (r_cnt != '0);

    // Bits [L-1:0] of the line; the L=LMAX case wraps to all ones on purpose.
    assign w_mask = (LMAX'(1) << i_latency) - LMAX'(1);
    // The top bit of the mask is bit L-1, the tap for a delay of L cycles.
    assign w_tap  = |(r_line & w_mask & ~(w_mask >> 1));

    always_comb begin
        w_cnt_nxt     = '0;
        w_line_nxt    = '0;
        w_overrun_set = 1'b0;
        w_assert      = 1'b0;
        w_busy        = 1'b0;
        case (r_mode_q)
            SHP_ECHO: begin
                w_busy   = w_cnt_nz;
                w_assert = (IMMEDIATE_BIT && i_trigger) || w_cnt_nz;
                if (w_trig) begin
                    w_cnt_nxt = i_latency;
                end else if (w_cnt_nz) begin
                    w_cnt_nxt = r_cnt - LAT_W'(1);
                end
            end
            SHP_TRIP: begin
                w_busy     = |(r_line & w_mask);
                w_assert   = (i_latency == '0) ? i_trigger : w_tap;
                w_line_nxt = (r_line << 1) | LMAX'(w_trig);
            end
            SHP_ONESHOT: begin
                w_busy   = w_cnt_nz;
                w_assert = (r_cnt == LAT_W'(1));
                if (w_cnt_nz) begin
                    w_cnt_nxt     = r_cnt - LAT_W'(1);
                    // Includes the pulse cycle itself (cnt==1): still busy.
                    w_overrun_set = w_trig;
                end else if (w_trig) begin
                    w_cnt_nxt = (i_latency == '0) ? LAT_W'(1) : i_latency;
                end
            end
            default: ;
        endcase
        // Kill and mode switch both clear state and silence every output path,
        // including the combinational trigger passthroughs.
        if (i_kill || w_mode_chg) begin
            w_assert   = 1'b0;
            w_cnt_nxt  = '0;
            w_line_nxt = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode_q  <= SHP_OFF;
            r_cnt     <= '0;
            r_line    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_mode_q <= i_mode;
            r_cnt    <= w_cnt_nxt;
            r_line   <= w_line_nxt;
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_assertion = w_assert;
    assign o_busy      = w_busy;
    assign o_overrun   = r_overrun;

endmodule

// File: rtl/assertion_shaper.sv
// Multi-channel pulse shaper: each channel stretches (echo), delays (trip)
// or converts to a delayed one-shot a single-cycle event, with its own
// latency, kill and sticky overrun status.
//   clk, rst     : clock, asynchronous active-high reset
//   trigger      : event input, one bit per channel
//   mode         : per-channel shape_mode_t, ch i = [2i+1:2i]
//   latency      : per-channel latency, ch i = [LAT_W*i +: LAT_W]
//   kill         : cancel pending activity per channel
//   clr_overrun  : clear sticky overrun per channel
//   assertion    : shaped outputs
//   busy         : channel holds pending state
//   overrun      : sticky one-shot drop indicator
module assertion_shaper
    import assertion_shaper_pkg::*;
#(
    parameter int                    CHANNELS  = SHP_DEF_CHANNELS,
    parameter int                    LAT_W     = SHP_DEF_LAT_W,
    parameter logic [CHANNELS-1:0]   IMMEDIATE = '1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       trigger,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [LAT_W*CHANNELS-1:0] latency,
    input  logic [CHANNELS-1:0]       kill,
    input  logic [CHANNELS-1:0]       clr_overrun,
    output logic [CHANNELS-1:0]       assertion,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       overrun
);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assertion_shaper_channel #(
            .LAT_W         (LAT_W),
            .IMMEDIATE_BIT (IMMEDIATE[gi])
        ) u_ch (
            .i_clk         (clk),
            .i_rst         (rst),
            .i_trigger     (trigger[gi]),
            .i_mode        (shape_mode_t'(mode[2*gi +: 2])),
            .i_latency     (latency[LAT_W*gi +: LAT_W]),
            .i_kill        (kill[gi]),
            .i_clr_overrun (clr_overrun[gi]),
            .o_assertion   (assertion[gi]),
            .o_busy        (busy[gi]),
            .o_overrun     (overrun[gi])
        );
    end

endmodule

// File: tb/tb_assertion_shaper.sv
// Bench for assertion_shaper: directed scenarios followed by randomized
// traffic, all checked against an event-time reference model.
module tb_assertion_shaper;
    import assertion_shaper_pkg::*;

    localparam int CH   = 4;
    localparam int LW   = 3;
    localparam int NCYC = 2048;
    localparam logic [CH-1:0] IMM = 4'b0111;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     trigger;
    logic [2*CH-1:0]   mode;
    logic [LW*CH-1:0]  latency;
    logic [CH-1:0]     kill;
    logic [CH-1:0]     clr_overrun;
    logic [CH-1:0]     assertion;
    logic [CH-1:0]     busy;
    logic [CH-1:0]     overrun;

    int total = 0;
    int bad   = 0;
    int now   = 0;

    // Reference model: events are kept as absolute cycle numbers.
    logic [CH-1:0] imm_v;
    int            m_mq[CH];
    int            echo_set[CH];
    int            echo_until[CH];
    int            os_arm[CH];
    int            os_fire[CH];
    int            clear_at[CH];
    bit            hist[CH][NCYC];
    logic [CH-1:0] m_ovr;

    assertion_shaper #(
        .CHANNELS  (CH),
        .LAT_W     (LW),
        .IMMEDIATE (IMM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trigger     (trigger),
        .mode        (mode),
        .latency     (latency),
        .kill        (kill),
        .clr_overrun (clr_overrun),
        .assertion   (assertion),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, now, got, exp);
        end
    endtask

    function automatic bit hv(input int ch, input int c);
        if (c < 0 || c >= NCYC) return 1'b0;
        return (c > clear_at[ch]) && hist[ch][c];
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < CH; ch++) begin
            m_mq[ch]       = int'(SHP_OFF);
            echo_set[ch]   = -1;
            echo_until[ch] = -1;
            os_arm[ch]     = -1;
            os_fire[ch]    = -1;
            clear_at[ch]   = now - 1;
        end
        m_ovr = '0;
    endtask

    task automatic model_eval(output logic [CH-1:0] ea, output logic [CH-1:0] eb);
        ea = '0;
        eb = '0;
        for (int ch = 0; ch < CH; ch++) begin
            int md;
            int lat;
            bit a;
            bit b;
            md  = int'(mode[2*ch +: 2]);
            lat = int'(latency[LW*ch +: LW]);
            a   = 1'b0;
            b   = 1'b0;
            if (m_mq[ch] == int'(SHP_ECHO)) begin
                b = (now > echo_set[ch]) && (now <= echo_until[ch]);
                a = (imm_v[ch] && trigger[ch]) || b;
            end else if (m_mq[ch] == int'(SHP_TRIP)) begin
                for (int k = 1; k <= lat; k++) if (hv(ch, now - k)) b = 1'b1;
                a = (lat == 0) ? trigger[ch] : hv(ch, now - lat);
            end else if (m_mq[ch] == int'(SHP_ONESHOT)) begin
                b = (now > os_arm[ch]) && (now <= os_fire[ch]);
                a = (now == os_fire[ch]);
            end
            if (md != m_mq[ch] || kill[ch]) a = 1'b0;
            ea[ch] = a;
            eb[ch] = b;
        end
    endtask

    task automatic model_step();
        for (int ch = 0; ch < CH; ch++) begin
            int md;
            int lat;
            bit chg;
            bit eff;
            bit os_busy;
            md      = int'(mode[2*ch +: 2]);
            lat     = int'(latency[LW*ch +: LW]);
            chg     = (md != m_mq[ch]);
            eff     = trigger[ch] && !kill[ch] && !chg;
            os_busy = (m_mq[ch] == int'(SHP_ONESHOT)) && (now > os_arm[ch]) && (now <= os_fire[ch]);
            if (os_busy && eff) m_ovr[ch] = 1'b1;
            else if (clr_overrun[ch]) m_ovr[ch] = 1'b0;
            if (kill[ch] || chg) begin
                clear_at[ch]   = now;
                echo_set[ch]   = -1;
                echo_until[ch] = -1;
                os_arm[ch]     = -1;
                os_fire[ch]    = -1;
            end else if (m_mq[ch] == int'(SHP_ECHO)) begin
                if (eff) begin
                    echo_set[ch]   = now;
                    echo_until[ch] = now + lat;
                end
            end else if (m_mq[ch] == int'(SHP_TRIP)) begin
                if (now < NCYC) hist[ch][now] = eff;
            end else if (m_mq[ch] == int'(SHP_ONESHOT)) begin
                if (eff && !os_busy) begin
                    os_arm[ch]  = now;
                    os_fire[ch] = now + ((lat == 0) ? 1 : lat);
                end
            end
            m_mq[ch] = md;
        end
    endtask

    // Compare on the falling edge, then advance the model with the DUT edge.
    task automatic cycle();
        logic [CH-1:0] ea;
        logic [CH-1:0] eb;
        @(negedge clk);
        model_eval(ea, eb);
        check("assertion", 32'(assertion), 32'(ea));
        check("busy", 32'(busy), 32'(eb));
        check("overrun", 32'(overrun), 32'(m_ovr));
        @(posedge clk);
        model_step();
        now++;
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [1:0] md, input int lat);
        mode[2*ch +: 2]     = md;
        latency[LW*ch +: LW] = LW'(lat);
    endtask

    initial begin
        logic [5:0] tp;
        logic       exp_b;
        imm_v       = IMM;
        rst         = 1'b1;
        trigger     = '1;
        mode        = {CH{SHP_TRIP}};
        latency     = '0;
        kill        = '0;
        clr_overrun = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({assertion, busy, overrun}), 32'(0));
        trigger = '0;
        mode    = '0;
        rst     = 1'b0;
        now++;
        model_reset();

        // Echo L=3: ch0 with immediate path, ch3 without.
        set_ch(0, SHP_ECHO, 3);
        set_ch(3, SHP_ECHO, 3);
        repeat (2) cycle();
        for (int k = 0; k < 5; k++) begin
            trigger = (k == 0) ? 4'b1001 : 4'b0000;
            #1;
            check("t1_echo_imm_a", 32'(assertion[0]), 32'(k <= 3));
            check("t1_echo_imm_busy", 32'(busy[0]), 32'(k >= 1 && k <= 3));
            check("t1_echo_noimm_a", 32'(assertion[3]), 32'(k >= 1 && k <= 3));
            cycle();
        end

        // Trip L=2 then L=0 passthrough on ch1.
        set_ch(1, SHP_TRIP, 2);
        repeat (2) cycle();
        tp = 6'b001101;
        for (int k = 0; k < 6; k++) begin
            trigger = 4'(tp[k]) << 1;
            exp_b   = (k >= 2) ? tp[k-2] : 1'b0;
            #1;
            check("t2_trip_l2", 32'(assertion[1]), 32'(exp_b));
            cycle();
        end
        set_ch(1, SHP_TRIP, 0);
        for (int k = 0; k < 6; k++) begin
            trigger = 4'($urandom_range(0, 1)) << 1;
            #1;
            check("t2_trip_l0", 32'(assertion[1]), 32'(trigger[1]));
            cycle();
        end

        // One-shot L=4 on ch2: overrun from a retrigger, clear, pulse-cycle drop.
        trigger = '0;
        set_ch(2, SHP_ONESHOT, 4);
        repeat (2) cycle();
        for (int k = 0; k < 8; k++) begin
            trigger        = '0;
            trigger[2]     = (k == 0 || k == 2);
            clr_overrun[2] = (k == 6);
            #1;
            check("t3_os_a", 32'(assertion[2]), 32'(k == 4));
            check("t3_os_ovr", 32'(overrun[2]), 32'(k >= 3 && k <= 6));
            cycle();
        end
        clr_overrun = '0;
        for (int k = 0; k < 10; k++) begin
            trigger    = '0;
            trigger[2] = (k == 0 || k == 4);
            #1;
            check("t3_os_pulse_drop_a", 32'(assertion[2]), 32'(k == 4));
            check("t3_os_pulse_drop_ovr", 32'(overrun[2]), 32'(k >= 5));
            cycle();
        end
        trigger     = '0;
        clr_overrun = 4'b0100;
        cycle();
        clr_overrun = '0;

        // Echo L=7 with kill on ch0, then kill with coincident trigger.
        set_ch(0, SHP_ECHO, 7);
        cycle();
        for (int k = 0; k < 5; k++) begin
            trigger    = '0;
            kill       = '0;
            trigger[0] = (k == 0);
            kill[0]    = (k == 2);
            #1;
            check("t4_kill_a", 32'(assertion[0]), 32'(k <= 1));
            check("t4_kill_busy", 32'(busy[0]), 32'(k == 1 || k == 2));
            cycle();
        end
        trigger = 4'b0001;
        kill    = 4'b0001;
        #1;
        check("t4_kill_trig_a", 32'(assertion[0]), 32'(0));
        cycle();
        trigger = '0;
        kill    = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_kill_trig_idle", 32'({assertion[0], busy[0]}), 32'(0));
            cycle();
        end

        // Mode switch trip -> echo on ch1 discards the pending delay.
        set_ch(1, SHP_TRIP, 3);
        kill = 4'b0010;
        cycle();
        kill       = '0;
        trigger[1] = 1'b1;
        #1;
        check("t5_trip_c0", 32'(assertion[1]), 32'(0));
        cycle();
        set_ch(1, SHP_ECHO, 3);
        #1;
        check("t5_switch_c1", 32'(assertion[1]), 32'(0));
        cycle();
        set_ch(1, SHP_ECHO, 0);
        #1;
        check("t5_echo_c2", 32'(assertion[1]), 32'(1));
        cycle();
        trigger = '0;
        #1;
        check("t5_no_c3", 32'({assertion[1], busy[1]}), 32'(0));
        cycle();

        // Async reset with every channel busy.
        set_ch(0, SHP_ECHO, 7);
        set_ch(1, SHP_TRIP, 3);
        set_ch(2, SHP_ONESHOT, 5);
        set_ch(3, SHP_ECHO, 7);
        cycle();
        trigger = '1;
        repeat (2) cycle();
        #1;
        check("t6_pre_busy", 32'(busy), 32'(4'hF));
        check("t6_pre_ovr", 32'(overrun[2]), 32'(1));
        rst = 1'b1;
        #1;
        check("t6_rst_assert", 32'(assertion), 32'(0));
        check("t6_rst_busy_ovr", 32'({busy, overrun}), 32'(0));
        @(posedge clk);
        #1;
        check("t6_rst_held", 32'({assertion, busy, overrun}), 32'(0));
        rst     = 1'b0;
        trigger = '0;
        now++;
        model_reset();

        // Randomized concurrent traffic, modes occasionally switched.
        for (int n = 0; n < 400; n++) begin
            trigger     = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            kill        = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
            clr_overrun = ($urandom_range(0, 7) == 0) ? 4'hF : 4'b0;
            for (int ch = 0; ch < CH; ch++) begin
                if ($urandom_range(0, 9) == 0) latency[LW*ch +: LW] = LW'($urandom_range(0, 7));
                if ($urandom_range(0, 59) == 0) mode[2*ch +: 2] = 2'($urandom_range(0, 3));
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog cycle=%0d got=timeout exp=finish", now);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
